// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} after WIDTH steps; divide-by-zero short-cuts to a zero result.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               div_ready
);

  localparam int unsigned CW  = $clog2(WIDTH);
  localparam int unsigned WRW = 2 * WIDTH + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIVZERO = 2'd1;
  localparam logic [1:0] S_ON      = 2'd2;
  localparam logic [1:0] S_END     = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WRW-1:0]     work_q, work_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               sign_q, sign_d;
  logic               neg_a_q, neg_a_d;
  logic               neg_b_q, neg_b_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   abs_a_c, abs_b_c;
  logic [WIDTH+1:0]   trial_c;
  logic [WIDTH-1:0]   q_raw_c, r_raw_c, q_fix_c, r_fix_c;

  // Operand magnitudes; only signed divides take the absolute value.
  assign abs_a_c = (sign && opdata1[WIDTH-1]) ? (WIDTH'(0) - opdata1) : opdata1;
  assign abs_b_c = (sign && opdata2[WIDTH-1]) ? (WIDTH'(0) - opdata2) : opdata2;

  // Trial subtraction on the shifted partial remainder; bit WIDTH+1 is the borrow.
  assign trial_c = work_q[WRW-1:WIDTH-1] - {2'b00, divisor_q};

  // Sign fix-up: quotient negative on sign mismatch, remainder follows the dividend.
  assign q_raw_c = work_q[WIDTH-1:0];
  assign r_raw_c = work_q[2*WIDTH-1:WIDTH];
  assign q_fix_c = (sign_q && (neg_a_q ^ neg_b_q)) ? (WIDTH'(0) - q_raw_c) : q_raw_c;
  assign r_fix_c = (sign_q && neg_a_q) ? (WIDTH'(0) - r_raw_c) : r_raw_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    sign_d    = sign_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    result_d  = result_q;
    ready_d   = ready_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b0;
        if (!annul && start) begin
          if (opdata2 == '0) begin
            state_d = S_DIVZERO;
          end else begin
            divisor_d = abs_b_c;
            sign_d    = sign;
            neg_a_d   = opdata1[WIDTH-1];
            neg_b_d   = opdata2[WIDTH-1];
            work_d    = {(WIDTH + 1)'(0), abs_a_c};
            cnt_d     = '0;
            state_d   = S_ON;
          end
        end
      end
      S_DIVZERO: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          result_d = '0;
          ready_d  = 1'b1;
          state_d  = S_END;
        end
      end
      S_ON: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          if (!trial_c[WIDTH+1]) begin
            work_d = {trial_c[WIDTH:0], work_q[WIDTH-2:0], 1'b1};
          end else begin
            work_d = {work_q[WRW-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_END;
          end
        end
      end
      S_END: begin
        if (annul || !start) begin
          ready_d = 1'b0;
          state_d = S_IDLE;
        end else if (!ready_q) begin
          result_d = {r_fix_c, q_fix_c};
          ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      sign_q    <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      sign_q    <= sign_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result    = result_q;
  assign div_ready = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for quotient/remainder/latency,
// plus hand sequences for annul, mid-division reset and start+annul in IDLE.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sign;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        div_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign      (sign),
    .annul     (annul),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .result    (result),
    .div_ready (div_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge; E0 is the next posedge. Operands are scrambled after E0.
  task automatic run_div(input string nm, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    sign = sg; opdata1 = a; opdata2 = b; start = 1'b1; annul = 1'b0;
    while (n < 60 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (div_ready) got = 1'b1;
      if (n == 1) begin
        opdata1 = ~a;
        opdata2 = b ^ 32'h5;
        sign    = ~sg;
      end
    end
    chk({nm, "_lat"}, 64'(got ? n - 1 : -1), 64'(lat));
    chk({nm, "_res"}, result, exp);
    repeat (2) @(negedge clk);
    chk({nm, "_hold"}, {63'b0, div_ready}, 64'd1);
    start = 1'b0;
    @(negedge clk);
    chk({nm, "_drop"}, {63'b0, div_ready}, 64'd0);
    chk({nm, "_kept"}, result, exp);
  endtask

  initial begin
    bit seen;
    vecs[0]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[1]  = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_7FFFFFFF, 33};
    vecs[2]  = '{1'b1, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_00000000, 33};
    vecs[3]  = '{1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 33};
    vecs[4]  = '{1'b0, 32'd12345,    32'h00000000, 64'h00000000_00000000, 1};
    vecs[5]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33};
    vecs[6]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33};
    vecs[7]  = '{1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 33};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF, 33};
    vecs[9]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33};
    vecs[10] = '{1'b0, 32'd5,        32'd7,        64'h00000005_00000000, 33};
    vecs[11] = '{1'b1, 32'hFFFFFFFF, 32'h00000000, 64'h00000000_00000000, 1};

    rst = 1'b1; start = 1'b0; sign = 1'b0; annul = 1'b0; opdata1 = '0; opdata2 = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {63'b0, div_ready}, 64'd0);
    chk("reset_result", result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      @(negedge clk);
    end

    // Annul after 10 cycles of a division; a fresh divide must then take full latency.
    seen = 1'b0;
    sign = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (div_ready) seen = 1'b1;
    end
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    annul = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (div_ready) seen = 1'b1;
    end
    chk("annul_no_ready", {63'b0, seen}, 64'd0);
    run_div("after_annul", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 33);
    @(negedge clk);

    // Synchronous reset in the middle of a division.
    sign = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {63'b0, div_ready}, 64'd0);
    chk("midrst_result", result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Start and annul together in IDLE must not launch a division.
    sign = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1; annul = 1'b1;
    repeat (2) @(negedge clk);
    chk("start_annul_ready", {63'b0, div_ready}, 64'd0);
    run_div("start_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
